// File: rtl/fpu_dispatch_sequencer_if.sv
// Signal bundle between the F-line dispatch sequencer and its CPU, prefetch, decoder
// and execute-unit neighbours. The sequencer uses the slave modport.
interface fpu_dispatch_sequencer_if;
  logic        start;
  logic [15:0] opcode_in;
  logic        supervisor;
  logic        ext_req;
  logic        ext_ack;
  logic [15:0] ext_data;
  logic [15:0] dec_opcode;
  logic [15:0] dec_ext;
  logic        dec_enable;
  logic        dec_valid;
  logic        dec_illegal;
  logic        dec_priv;
  logic        dec_needs_ext;
  logic [3:0]  dec_type;
  logic        exec_start;
  logic [3:0]  exec_type;
  logic        exec_done;
  logic        busy;
  logic        done;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [2:0]  dbg_state;

  modport slave (
    input  start, opcode_in, supervisor, ext_ack, ext_data,
           dec_valid, dec_illegal, dec_priv, dec_needs_ext, dec_type, exec_done,
    output ext_req, dec_opcode, dec_ext, dec_enable, exec_start, exec_type,
           busy, done, exc_valid, exc_code, dbg_state
  );

  modport master (
    output start, opcode_in, supervisor, ext_ack, ext_data,
           dec_valid, dec_illegal, dec_priv, dec_needs_ext, dec_type, exec_done,
    input  ext_req, dec_opcode, dec_ext, dec_enable, exec_start, exec_type,
           busy, done, exc_valid, exc_code, dbg_state
  );
endinterface

// File: rtl/fpu_dispatch_sequencer.sv
// Sequences one coprocessor-1 F-line instruction: extension fetch, one-cycle decode,
// legality/privilege check, dispatch to the execute unit and a watchdog-guarded wait.
module fpu_dispatch_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  fpu_dispatch_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_EXC      = 3'd6;

  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_PRIV    = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  // r_wd holds the number of completed WAIT cycles, so the current cycle is number
  // r_wd+1; the last allowed WAIT cycle is therefore r_wd == TIMEOUT_CYCLES-2.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [TO_W-1:0] WD_MAX  = '1;

  logic [2:0]      r_state;
  logic            r_super;
  logic [15:0]     r_opcode;
  logic [15:0]     r_ext;
  logic [3:0]      r_type;
  logic [1:0]      r_code;
  logic [TO_W-1:0] r_wd;

  logic w_dec_fault;
  logic w_priv_fault;
  logic w_timeout;
  logic w_unused;

  assign w_dec_fault  = bus.dec_illegal | ~bus.dec_valid;
  assign w_priv_fault = bus.dec_priv & ~r_super;
  assign w_timeout    = (r_wd >= WD_LAST);
  assign w_unused     = bus.dec_needs_ext;

  // Handshakes: ext_req stays high until a cycle with ext_ack (same-cycle ack allowed);
  // exec_start, done and exc_valid are single-cycle pulses with no back-pressure.
  assign bus.ext_req    = (r_state == S_FETCH);
  assign bus.dec_enable = (r_state == S_DECODE);
  assign bus.exec_start = (r_state == S_DISPATCH);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.exc_valid  = (r_state == S_EXC);
  assign bus.dec_opcode = r_opcode;
  assign bus.dec_ext    = r_ext;
  assign bus.exec_type  = r_type;
  assign bus.exc_code   = r_code;
  assign bus.dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_super  <= 1'b0;
      r_opcode <= '0;
      r_ext    <= '0;
      r_type   <= '0;
      r_code   <= '0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_opcode <= bus.opcode_in;
            r_super  <= bus.supervisor;
            r_ext    <= '0;
            r_code   <= '0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.ext_ack) begin
            r_ext   <= bus.ext_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_dec_fault) begin
            r_code  <= EXC_ILLEGAL;
            r_state <= S_EXC;
          end else if (w_priv_fault) begin
            r_code  <= EXC_PRIV;
            r_state <= S_EXC;
          end else begin
            r_type  <= bus.dec_type;
            r_state <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
          // A completion on the final allowed cycle beats the watchdog.
          if (bus.exec_done) begin
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_code  <= EXC_TIMEOUT;
            r_state <= S_EXC;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_EXC:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch_sequencer.sv
// Bench for fpu_dispatch_sequencer: directed vector table, hand-written reset/stray
// sequences, and randomized transactions checked against an outcome model.
module tb_fpu_dispatch_sequencer;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_dispatch_sequencer_if bus();

  fpu_dispatch_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Cycle numbers count posedges after the edge that samples start (start cycle = 0).
  typedef struct {
    logic [15:0] opcode;
    logic [15:0] ext;
    logic        sup;
    logic        ill;
    logic        vld;
    logic        priv;
    logic [3:0]  typ;
    int          ack_dly;
    int          done_dly;   // WAIT cycle carrying exec_done; 0 = never
    bit          stray;
    int          exp_es;     // exec_start cycle, -1 = none
    int          exp_end;    // done / exc_valid cycle
    logic [1:0]  exp_code;   // 0 = retired normally
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  logic [15:0] last_opcode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack(input logic [1:0] code, input logic [3:0] typ,
                                       input int es, input int fin);
    logic [7:0] es8;
    logic [7:0] fin8;
    es8  = 8'(es);
    fin8 = 8'(fin);
    return {2'b00, code, typ, es8, fin8};
  endfunction

  // Outcome model: decode happens ack_dly+2 cycles after start, dispatch the cycle after,
  // and the execute unit has TO-1 WAIT cycles to answer.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   dcyc;
    r    = v;
    dcyc = v.ack_dly + 2;
    if (v.ill || !v.vld) begin
      r.exp_es = -1; r.exp_end = dcyc + 1; r.exp_code = 2'b01;
    end else if (v.priv && !v.sup) begin
      r.exp_es = -1; r.exp_end = dcyc + 1; r.exp_code = 2'b10;
    end else begin
      r.exp_es = dcyc + 1;
      if (v.done_dly >= 1 && v.done_dly <= TO - 1) begin
        r.exp_end = r.exp_es + v.done_dly + 1; r.exp_code = 2'b00;
      end else begin
        r.exp_end = r.exp_es + TO; r.exp_code = 2'b11;
      end
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus.start = 0; bus.opcode_in = '0; bus.supervisor = 0; bus.ext_ack = 0;
    bus.ext_data = '0; bus.dec_valid = 0; bus.dec_illegal = 0; bus.dec_priv = 0;
    bus.dec_needs_ext = 0; bus.dec_type = '0; bus.exec_done = 0;
  endtask

  task automatic run_txn(input vec_t v);
    int es_seen, end_seen, n_es, n_en;
    logic [1:0]  code_seen;
    logic [3:0]  typ_seen;
    logic [23:0] exp_w;
    exp_q.push_back(pack(v.exp_code, (v.exp_es >= 0) ? v.typ : 4'h0, v.exp_es, v.exp_end));
    @(negedge clk);
    bus.start = 1; bus.opcode_in = v.opcode; bus.supervisor = v.sup; bus.ext_data = v.ext;
    bus.dec_valid = v.vld; bus.dec_illegal = v.ill; bus.dec_priv = v.priv;
    bus.dec_needs_ext = 1; bus.dec_type = v.typ;
    es_seen = -1; end_seen = 0; n_es = 0; n_en = 0; code_seen = 0; typ_seen = 0;
    for (int n = 1; n <= 60 && end_seen == 0; n++) begin
      @(negedge clk);
      if (bus.dec_enable) n_en++;
      if (bus.exec_start) begin n_es++; es_seen = n; typ_seen = bus.exec_type; end
      if (bus.done) begin end_seen = n; code_seen = 2'b00; end
      if (bus.exc_valid) begin end_seen = n; code_seen = bus.exc_code; end
      bus.opcode_in  = ~v.opcode;
      bus.supervisor = ~v.sup;
      bus.start      = v.stray && end_seen == 0 && ($urandom_range(0, 2) == 0);
      bus.ext_ack    = (n == 1 + v.ack_dly);
      bus.exec_done  = (v.done_dly > 0 && es_seen >= 0 && n == es_seen + v.done_dly);
    end
    bus.start = 0; bus.ext_ack = 0; bus.exec_done = 0;
    exp_w = exp_q.pop_front();
    chk("outcome{code,type,es,end}", pack(code_seen, typ_seen, es_seen, end_seen), exp_w);
    chk("exec_start_count", 32'(n_es), (v.exp_es >= 0) ? 32'd1 : 32'd0);
    chk("dec_enable_count", 32'(n_en), 32'd1);
    chk("dec_opcode", 32'(bus.dec_opcode), 32'(v.opcode));
    chk("dec_ext", 32'(bus.dec_ext), 32'(v.ext));
    @(negedge clk);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("exc_code_held", 32'(bus.exc_code), 32'(v.exp_code));
    last_opcode = v.opcode;
  endtask

  task automatic check_reset_state(input string name);
    chk(name, {bus.ext_req, bus.dec_enable, bus.exec_start, bus.busy, bus.done,
               bus.exc_valid, bus.exc_code, bus.dbg_state, bus.exec_type, bus.dec_opcode}, 32'd0);
    chk({name, "_ext"}, 32'(bus.dec_ext), 32'd0);
  endtask

  task automatic no_pulse_window(input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.exc_valid || bus.busy) pulses++;
    end
    chk(name, 32'(pulses), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    int   guard;
    idle_inputs();
    last_opcode = '0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    check_reset_state("reset_state");

    //           opcode    ext      S  ill vld prv typ ack done stray es  end code
    tbl[0] = '{16'hF200, 16'h0422, 0, 0, 1, 0, 4'd0, 0, 5,  0,  3,  9, 2'b00};
    tbl[1] = '{16'hF400, 16'h0000, 0, 1, 0, 0, 4'd0, 0, 0,  0, -1,  3, 2'b01};
    tbl[2] = '{16'hF310, 16'h0000, 0, 0, 1, 1, 4'd7, 0, 3,  0, -1,  3, 2'b10};
    tbl[3] = '{16'hF310, 16'h0000, 1, 0, 1, 1, 4'd7, 0, 3,  0,  3,  7, 2'b00};
    tbl[4] = '{16'hF200, 16'h0422, 0, 0, 1, 0, 4'd2, 0, 0,  1,  3, 19, 2'b11};
    tbl[5] = '{16'hF200, 16'h0422, 0, 0, 1, 0, 4'd2, 0, 15, 1,  3, 19, 2'b00};
    tbl[6] = '{16'hF228, 16'h5A5A, 1, 0, 1, 1, 4'd4, 3, 1,  1,  6,  8, 2'b00};
    tbl[7] = '{16'hF300, 16'h0000, 0, 1, 1, 1, 4'd0, 1, 0,  0, -1,  4, 2'b01};
    tbl[8] = '{16'hF280, 16'hFFFF, 1, 0, 0, 0, 4'd3, 2, 0,  0, -1,  5, 2'b01};
    tbl[9] = '{16'hF200, 16'h0422, 0, 0, 1, 0, 4'd9, 0, 16, 0,  3, 19, 2'b11};
    foreach (tbl[i]) run_txn(tbl[i]);

    // Stray ext_ack / exec_done while idle must not wake the sequencer.
    @(negedge clk);
    bus.ext_ack = 1; bus.exec_done = 1; bus.ext_data = 16'hDEAD;
    no_pulse_window("idle_strays");
    bus.ext_ack = 0; bus.exec_done = 0;
    chk("idle_opcode_kept", 32'(bus.dec_opcode), 32'(last_opcode));

    // Reset while in FETCH.
    @(negedge clk);
    bus.start = 1; bus.opcode_in = 16'hF2AA; bus.dec_valid = 1;
    @(negedge clk);
    bus.start = 0;
    chk("in_fetch", 32'(bus.ext_req), 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check_reset_state("reset_in_fetch");
    no_pulse_window("no_pulse_fetch");

    // Reset while in WAIT_EXEC.
    @(negedge clk);
    bus.start = 1; bus.opcode_in = 16'hF255; bus.dec_valid = 1; bus.dec_type = 4'd5;
    @(negedge clk);
    bus.start = 0; bus.ext_ack = 1;
    guard = 0;
    while (!bus.exec_start && guard < 20) begin
      @(negedge clk);
      bus.ext_ack = 0;
      guard++;
    end
    chk("reached_dispatch", 32'(bus.exec_start), 32'd1);
    repeat (3) @(negedge clk);
    chk("in_wait", 32'(bus.busy), 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check_reset_state("reset_in_wait");
    no_pulse_window("no_pulse_wait");
    idle_inputs();

    for (int k = 0; k < 40; k++) begin
      v.opcode   = {4'hF, 12'($urandom_range(0, 4095))};
      v.ext      = 16'($urandom_range(0, 65535));
      v.sup      = 1'($urandom_range(0, 1));
      v.ill      = ($urandom_range(0, 4) == 0);
      v.vld      = ($urandom_range(0, 5) != 0);
      v.priv     = 1'($urandom_range(0, 1));
      v.typ      = 4'($urandom_range(0, 15));
      v.ack_dly  = $urandom_range(0, 4);
      v.done_dly = $urandom_range(0, 20);
      v.stray    = 1'($urandom_range(0, 1));
      v.exp_es = 0; v.exp_end = 0; v.exp_code = 0;
      run_txn(model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
